// File: rtl/enclave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enclave_pkg
//  Description : Shared encodings for the enclave Wishbone command master:
//                command kinds, opcodes, opcode-word field layout and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package enclave_pkg;

  // Command kinds presented on cmd_kind
  localparam logic [1:0] CMD_WRITE   = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_OPCODE  = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  // Enclave operations carried in opcode word bits [1:0]
  localparam logic [1:0] OP_ENCRYPT = 2'd0;
  localparam logic [1:0] OP_DECRYPT = 2'd1;
  localparam logic [1:0] OP_ADD     = 2'd2;
  localparam logic [1:0] OP_MUL     = 2'd3;

  // Opcode word layout for the default 9-bit operand-address fields
  localparam int OP_LSB    = 0;
  localparam int OP_W      = 2;
  localparam int FIELD_W   = 9;
  localparam int SRC0_LSB  = 2;
  localparam int SRC1_LSB  = 11;
  localparam int DST_LSB   = 20;
  localparam int START_BIT = 31;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUS  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/enclave_wb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : enclave_wb_master_if
//  Description : Command stream, response stream and Wishbone initiator
//                signals of the enclave bus master, bundled in one interface.
//                master = the bus-master block, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface enclave_wb_master_if;

  // Command stream
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_kind;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;

  // Response stream
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // Wishbone initiator side
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_kind, cmd_addr, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_kind, cmd_addr, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface
`default_nettype wire

// File: rtl/enclave_opcode_pack.sv
`default_nettype none
// ============================================================================
//  Module      : enclave_opcode_pack
//  Description : Combinational assembly of an enclave opcode word:
//                start bit at 31, then dst / src1 / src0 / op packed from LSB.
//                Bits between the dst field and the start bit read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module enclave_opcode_pack
  import enclave_pkg::*;
#(
  parameter int ADDR_WIDTH = FIELD_W
) (
  input  logic [1:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] src0_i,
  input  logic [ADDR_WIDTH-1:0] src1_i,
  input  logic [ADDR_WIDTH-1:0] dst_i,
  output logic [31:0]           word_o
);

  localparam int SRC0_POS = OP_LSB + OP_W;
  localparam int SRC1_POS = SRC0_POS + ADDR_WIDTH;
  localparam int DST_POS  = SRC1_POS + ADDR_WIDTH;

  // Place each field at its slot and raise the start bit
  always_comb begin
    word_o                             = '0;
    word_o[OP_LSB +: OP_W]             = op_i;
    word_o[SRC0_POS +: ADDR_WIDTH]     = src0_i;
    word_o[SRC1_POS +: ADDR_WIDTH]     = src1_i;
    word_o[DST_POS +: ADDR_WIDTH]      = dst_i;
    word_o[START_BIT]                  = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/enclave_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : enclave_wb_master
//  Description : Wishbone initiator for the enclave slave port. Turns one
//                command (write / read / opcode) into one classic Wishbone
//                cycle and returns exactly one response. Opcode writes are
//                followed by a fixed compute wait; a slave that never acks
//                is aborted after TIMEOUT strobe cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module enclave_wb_master
  import enclave_pkg::*;
#(
  parameter logic [31:0] OPCODE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH   = 9,
  parameter int          COMPUTE_WAIT = 16,
  parameter int          TIMEOUT      = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  enclave_wb_master_if.master bus,
  output logic                busy
);

  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_BUS  = S_BUS;
  localparam logic [2:0] ST_WAIT = S_WAIT;
  localparam logic [2:0] ST_RESP = S_RESP;

  localparam int SRC0_POS = OP_LSB + OP_W;
  localparam int SRC1_POS = SRC0_POS + ADDR_WIDTH;
  localparam int DST_POS  = SRC1_POS + ADDR_WIDTH;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int WT_W = $clog2(COMPUTE_WAIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(COMPUTE_WAIT - 1);

  logic [2:0]      state_q,    state_d;
  logic            cyc_q,      cyc_d;
  logic            stb_q,      stb_d;
  logic            we_q,       we_d;
  logic [3:0]      sel_q,      sel_d;
  logic [31:0]     adr_q,      adr_d;
  logic [31:0]     dat_q,      dat_d;
  logic            is_op_q,    is_op_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q,  rsp_err_d;
  logic [TO_W-1:0] to_cnt_q,   to_cnt_d;
  logic [WT_W-1:0] wt_cnt_q,   wt_cnt_d;

  logic [31:0]     op_word;

  enclave_opcode_pack #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_opcode_pack (
    .op_i   (bus.cmd_data[OP_LSB +: OP_W]),
    .src0_i (bus.cmd_data[SRC0_POS +: ADDR_WIDTH]),
    .src1_i (bus.cmd_data[SRC1_POS +: ADDR_WIDTH]),
    .dst_i  (bus.cmd_data[DST_POS +: ADDR_WIDTH]),
    .word_o (op_word)
  );

  // Handshake and bus outputs are straight decodes of state / registers
  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_err   = rsp_err_q;
    bus.wbm_cyc_o = cyc_q;
    bus.wbm_stb_o = stb_q;
    bus.wbm_we_o  = we_q;
    bus.wbm_sel_o = sel_q;
    bus.wbm_adr_o = adr_q;
    bus.wbm_dat_o = dat_q;
    busy          = (state_q != ST_IDLE);
  end

  // Next-state logic for the command sequencer and its two counters
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    is_op_d    = is_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    to_cnt_d   = to_cnt_q;
    wt_cnt_d   = wt_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          to_cnt_d   = '0;
          wt_cnt_d   = '0;
          if (bus.cmd_kind == CMD_ILLEGAL) begin
            // Rejected outright: no bus traffic, error response only
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            sel_d   = 4'hF;
            state_d = ST_BUS;
            case (bus.cmd_kind)
              CMD_WRITE: begin
                adr_d   = bus.cmd_addr;
                dat_d   = bus.cmd_data;
                we_d    = 1'b1;
                is_op_d = 1'b0;
              end
              CMD_READ: begin
                adr_d   = bus.cmd_addr;
                dat_d   = '0;
                we_d    = 1'b0;
                is_op_d = 1'b0;
              end
              default: begin
                adr_d   = OPCODE_ADDR;
                dat_d   = op_word;
                we_d    = 1'b1;
                is_op_d = 1'b1;
              end
            endcase
          end
        end
      end

      ST_BUS: begin
        if (bus.wbm_ack_i) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = 4'h0;
          to_cnt_d = '0;
          if (is_op_q) begin
            state_d = ST_WAIT;
          end else begin
            if (!we_q) begin
              rsp_data_d = bus.wbm_dat_i;
            end
            state_d = ST_RESP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Slave never answered: abandon the cycle, opcode skips the wait
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = 4'h0;
          to_cnt_d   = '0;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_WAIT: begin
        if (wt_cnt_q == WT_LAST) begin
          wt_cnt_d  = '0;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          wt_cnt_d = wt_cnt_q + WT_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any cycle in flight
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      adr_q      <= '0;
      dat_q      <= '0;
      is_op_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      to_cnt_q   <= '0;
      wt_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      is_op_q    <= is_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      to_cnt_q   <= to_cnt_d;
      wt_cnt_q   <= wt_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enclave_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enclave_wb_master
//  Description : Directed self-checking bench for enclave_wb_master.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enclave_wb_master;
  import enclave_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  enclave_wb_master_if bus();

  enclave_wb_master #(
    .OPCODE_ADDR  (32'h3000_0000),
    .ADDR_WIDTH   (9),
    .COMPUTE_WAIT (16),
    .TIMEOUT      (64)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Present one command for a single cycle (caller is at a falling edge, DUT idle)
  task automatic send_cmd(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_kind  = kind;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Accept the current response for one cycle
  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o} !== 7'b0)
      begin errors++; $display("FAIL reset_bus_ctl: got %b expected 0", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}); end
    checks++; if ({bus.wbm_adr_o, bus.wbm_dat_o} !== 64'h0)
      begin errors++; $display("FAIL reset_adr_dat: got %h expected 0", {bus.wbm_adr_o, bus.wbm_dat_o}); end
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== 34'h0)
      begin errors++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}); end
    checks++; if ({bus.cmd_ready, busy} !== 2'b10)
      begin errors++; $display("FAIL reset_ready_busy: got %b expected 10", {bus.cmd_ready, busy}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    checks++; if (bus.cmd_ready !== 1'b1)
      begin errors++; $display("FAIL write_cmd_ready: got %b expected 1", bus.cmd_ready); end
    send_cmd(CMD_WRITE, 32'h3000_0004, 32'd10);
    checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o} !== 7'b111_1111)
      begin errors++; $display("FAIL write_ctl: got %b expected 1111111", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}); end
    checks++; if (bus.wbm_adr_o !== 32'h3000_0004)
      begin errors++; $display("FAIL write_adr: got %h expected 30000004", bus.wbm_adr_o); end
    checks++; if (bus.wbm_dat_o !== 32'd10)
      begin errors++; $display("FAIL write_dat: got %h expected 0000000a", bus.wbm_dat_o); end
    checks++; if ({bus.cmd_ready, busy, bus.rsp_valid} !== 3'b010)
      begin errors++; $display("FAIL write_busy: got %b expected 010", {bus.cmd_ready, busy, bus.rsp_valid}); end
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o} !== 3'b000)
      begin errors++; $display("FAIL write_drop: got %b expected 000", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}); end
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b10, 32'h0})
      begin errors++; $display("FAIL write_rsp: got %h expected %h", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b10, 32'h0}); end
    take_rsp();
    checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01)
      begin errors++; $display("FAIL write_done: got %b expected 01", {bus.rsp_valid, bus.cmd_ready}); end
  endtask

  task automatic test_read(input logic [31:0] addr, input int waits, input logic [31:0] rdata);
    int cyc_cnt = 0;
    bit bad     = 1'b0;
    bus.wbm_dat_i = 32'hDEAD_BEEF;
    send_cmd(CMD_READ, addr, 32'h0);
    for (int i = 0; i <= waits; i++) begin
      if (bus.wbm_cyc_o === 1'b1) cyc_cnt++;
      if (bus.wbm_we_o !== 1'b0 || bus.wbm_adr_o !== addr || bus.wbm_stb_o !== 1'b1) bad = 1'b1;
      if (i == waits) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = rdata;
      end
      @(negedge clk);
    end
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'hDEAD_BEEF;
    checks++; if (cyc_cnt !== waits + 1)
      begin errors++; $display("FAIL read_cyc_len: got %0d expected %0d", cyc_cnt, waits + 1); end
    checks++; if (bad !== 1'b0)
      begin errors++; $display("FAIL read_bus_stable: got %b expected 0", bad); end
    checks++; if ({bus.wbm_cyc_o, bus.rsp_valid, bus.rsp_err} !== 3'b010)
      begin errors++; $display("FAIL read_rsp_flags: got %b expected 010", {bus.wbm_cyc_o, bus.rsp_valid, bus.rsp_err}); end
    checks++; if (bus.rsp_data !== rdata)
      begin errors++; $display("FAIL read_data: got %h expected %h", bus.rsp_data, rdata); end
    take_rsp();
  endtask

  task automatic test_opcode();
    int  n   = 0;
    bit  bad = 1'b0;
    send_cmd(CMD_OPCODE, 32'h1234_5678, {3'b000, 9'd50, 9'd100, 9'd0, OP_ADD});
    checks++; if (bus.wbm_adr_o !== 32'h3000_0000)
      begin errors++; $display("FAIL op_adr: got %h expected 30000000", bus.wbm_adr_o); end
    checks++; if (bus.wbm_dat_o !== 32'h8323_2002)
      begin errors++; $display("FAIL op_dat: got %h expected 83232002", bus.wbm_dat_o); end
    checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o} !== 3'b111)
      begin errors++; $display("FAIL op_ctl: got %b expected 111", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}); end
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    // count idle-bus cycles before the response; one stray ack is injected meanwhile
    for (int i = 0; i < 40 && bus.rsp_valid !== 1'b1; i++) begin
      if (bus.wbm_cyc_o !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      bus.wbm_ack_i = (i == 3);
      n++;
      @(negedge clk);
    end
    bus.wbm_ack_i = 1'b0;
    checks++; if (n !== 16)
      begin errors++; $display("FAIL op_wait_len: got %0d expected 16", n); end
    checks++; if (bad !== 1'b0)
      begin errors++; $display("FAIL op_wait_idle: got %b expected 0", bad); end
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b10, 32'h0})
      begin errors++; $display("FAIL op_rsp: got %h expected %h", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b10, 32'h0}); end
    take_rsp();
  endtask

  task automatic test_timeout();
    int n = 0;
    bus.wbm_dat_i = 32'h5555_5555;
    send_cmd(CMD_READ, 32'h3000_01a4, 32'h0);
    for (int i = 0; i < 100 && bus.wbm_cyc_o === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 64)
      begin errors++; $display("FAIL timeout_len: got %0d expected 64", n); end
    checks++; if ({bus.wbm_stb_o, bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {3'b011, 32'h0})
      begin errors++; $display("FAIL timeout_rsp: got %h expected %h", {bus.wbm_stb_o, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {3'b011, 32'h0}); end
    take_rsp();
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.cmd_ready} !== 3'b001)
      begin errors++; $display("FAIL timeout_clear: got %b expected 001", {bus.rsp_valid, bus.rsp_err, bus.cmd_ready}); end
  endtask

  task automatic test_illegal();
    send_cmd(CMD_ILLEGAL, 32'h3000_0008, 32'hFFFF_FFFF);
    checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.rsp_err} !== 4'b0011)
      begin errors++; $display("FAIL illegal_rsp: got %b expected 0011", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.rsp_err}); end
    checks++; if (bus.rsp_data !== 32'h0)
      begin errors++; $display("FAIL illegal_data: got %h expected 0", bus.rsp_data); end
    take_rsp();
  endtask

  task automatic test_stray_ack();
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if ({bus.wbm_cyc_o, bus.rsp_valid, busy, bus.cmd_ready} !== 4'b0001)
      begin errors++; $display("FAIL stray_ack: got %b expected 0001", {bus.wbm_cyc_o, bus.rsp_valid, busy, bus.cmd_ready}); end
  endtask

  task automatic test_back_to_back();
    send_cmd(CMD_READ, 32'h3000_0020, 32'h0);
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'hA5A5_0001;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    // a write waits on cmd_valid while the response is held off
    bus.cmd_valid = 1'b1;
    bus.cmd_kind  = CMD_WRITE;
    bus.cmd_addr  = 32'h3000_0008;
    bus.cmd_data  = 32'd7;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.rsp_valid, bus.rsp_data, bus.cmd_ready, bus.wbm_cyc_o} !== {1'b1, 32'hA5A5_0001, 2'b00})
        begin errors++; $display("FAIL bp_hold%0d: got %h expected %h", i, {bus.rsp_valid, bus.rsp_data, bus.cmd_ready, bus.wbm_cyc_o}, {1'b1, 32'hA5A5_0001, 2'b00}); end
      @(negedge clk);
    end
    take_rsp();
    checks++; if ({bus.rsp_valid, bus.cmd_ready, bus.wbm_cyc_o} !== 3'b010)
      begin errors++; $display("FAIL b2b_idle: got %b expected 010", {bus.rsp_valid, bus.cmd_ready, bus.wbm_cyc_o}); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o} !== {2'b11, 32'h3000_0008, 32'd7})
      begin errors++; $display("FAIL b2b_write: got %h expected %h", {bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o}, {2'b11, 32'h3000_0008, 32'd7}); end
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b10, 32'h0})
      begin errors++; $display("FAIL b2b_rsp: got %h expected %h", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b10, 32'h0}); end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    send_cmd(CMD_READ, 32'h3000_0010, 32'h0);
    @(negedge clk);
    checks++; if (bus.wbm_cyc_o !== 1'b1)
      begin errors++; $display("FAIL rstmid_in_bus: got %b expected 1", bus.wbm_cyc_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, busy} !== 4'b0000)
      begin errors++; $display("FAIL rstmid_drop: got %b expected 0000", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, busy}); end
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0)
      begin errors++; $display("FAIL rstmid_after: got %b expected 0", seen); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_kind  = 2'b00;
    bus.cmd_addr  = 32'h0;
    bus.cmd_data  = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read(32'h3000_00cc, 3, 32'd30);
    test_read(32'h3000_00d0, 3, 32'd32);
    test_read(32'h3000_00d4, 0, 32'hCAFE_F00D);
    test_opcode();
    test_timeout();
    test_illegal();
    test_stray_ack();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/enclave_wb_master.md
Name: enclave_wb_master

Overview:
Hardware Wishbone initiator that drives the enclave user-project slave port from a simple command stream. It replaces hand-sequenced bus stimulus with one block: it loads ciphertext words, issues opcode words and reads results back. Each command produces exactly one response. It sits between an on-chip controller (or bench driver) and the enclave's wbs_* slave interface.

Parameters:
OPCODE_ADDR, 32'h30000000, address that opcode commands are written to
ADDR_WIDTH, 9, width of each operand-address field in the opcode word
COMPUTE_WAIT, 16, cycles to wait after an opcode write is acked, before the response is returned
TIMEOUT, 64, maximum cycles stb may stay high without ack before the cycle is aborted

Ports:
wb_clk_i  in  1  clock; the block uses this single clock
wb_rst_i  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_kind  in  2  00 write, 01 read, 10 opcode, 11 illegal
cmd_addr  in  32  bus address for write/read; ignored for opcode
cmd_data  in  32  write data; for opcode, [1:0] op, [10:2] src0, [19:11] src1, [28:20] dst
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  32  read data; 0 for write/opcode/error
rsp_err  out  1  timeout or illegal kind
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects, always 4'b1111 while in a cycle
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data
wbm_ack_i  in  1  slave acknowledge
wbm_dat_i  in  32  slave read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_err=0; rsp_data=0; cyc/stb/we=0; sel=0; adr=0; dat_o=0; wait and timeout counters=0.
- IDLE: cmd_ready=1 (combinational from state). On handshake:
  - kind 11: go to RESP with rsp_err=1; no bus cycle.
  - Otherwise: register adr, dat_o and we. Go to BUS; cyc=stb=1 and sel=4'b1111 from the next cycle.
- Opcode word assembly: {1'b1, 2'b00, cmd_data[28:0]}. Bit 31 is the start bit. Address is OPCODE_ADDR and we=1.
- BUS: signals stay stable until ack. ack is sampled at the clock edge. On the edge where ack=1:
  - cyc/stb/we drop on that edge (single classic cycle, 1-cycle minimum).
  - On a read, wbm_dat_i is captured into rsp_data.
  - Write or read goes to RESP. Opcode goes to WAIT.
- Timeout: the counter increments each BUS cycle. If it reaches TIMEOUT with no ack, drop cyc/stb, set rsp_err=1, rsp_data=0, and go to RESP. This applies to opcode commands too; they skip WAIT on timeout.
- WAIT: counts COMPUTE_WAIT cycles with cyc=0, then goes to RESP with rsp_err=0.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready. On handshake: clear rsp_valid and rsp_err, go to IDLE. The next command can be accepted the cycle after.
- ack while cyc=0 is ignored.
- Minimum latency, command accept to rsp_valid:
  - read/write: 2 cycles with zero-wait ack (accept edge, BUS edge with ack).
  - opcode: 2 + COMPUTE_WAIT cycles.
- Reset mid-operation (any state): return to reset values at the next edge. cyc/stb drop immediately and no response is issued for the aborted command.
- Only one outstanding command. cmd_ready=0 in BUS, WAIT and RESP.

Decomposition:
- Shared package enclave_pkg holds:
  - cmd_kind encodings (CMD_WRITE, CMD_READ, CMD_OPCODE);
  - opcode encodings (OP_ENCRYPT=0, OP_DECRYPT=1, OP_ADD=2, OP_MUL=3);
  - opcode field bit positions and the START_BIT=31 constant;
  - the FSM state enum.
- One sub-module, enclave_opcode_pack: combinational assembly of the opcode word from op/src0/src1/dst. It is shared with software-model checks.
- The FSM and counters live in the top module.

Test Plan:
- Write: cmd kind 00, addr 0x30000004, data 10, slave acks after 1 cycle -> exactly one cycle with cyc=stb=we=1, sel=4'hF, adr=0x30000004, dat_o=10. rsp_valid 2 cycles after accept with rsp_data=0, rsp_err=0.
- Read: kind 01, addr 0x300000cc, slave returns 30 after 3 wait cycles -> we=0 throughout, rsp_data=30, rsp_err=0. Repeat for addr 0x300000d0 returning 32.
- Opcode ADD: cmd_data op=2, src0=0, src1=100, dst=50 ->
  - wbm_adr_o=0x30000000, wbm_dat_o=0x83232002;
  - after ack, cyc=0 for exactly 16 cycles (COMPUTE_WAIT=16), then rsp_valid=1, rsp_err=0.
- Timeout and illegal kind:
  - Read to 0x300001a4 with ack never asserted (TIMEOUT=64) -> cyc drops after 64 BUS cycles, rsp_err=1, rsp_data=0.
  - kind 11 -> rsp_err=1 with no cyc assertion.
- Backpressure and reset:
  - rsp_ready held low 5 cycles -> rsp_valid, rsp_data stable; cmd_ready=0; a pending cmd_valid is not accepted.
  - wb_rst_i pulsed while in BUS -> cyc/stb=0 next cycle, no rsp_valid; cmd_ready=1 after reset releases.
